// File: rtl/axi_lite_timeout_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_timeout_bridge_if
//  Description : AXI4-Lite channel bundle (AW/W/B/AR/R) with master and
//                slave views, used on both sides of the timeout bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_timeout_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // write address / data / response
   logic                      awvalid;
   logic                      awready;
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic [2:0]                awprot;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   // read address / data
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [2:0]                arprot;
   logic                      rvalid;
   logic                      rready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_timeout_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_timeout_bridge
//  Description : Single-outstanding AXI4-Lite bridge. Forwards one write and
//                one read at a time downstream and answers SLVERR upstream if
//                the downstream slave does not respond within TIMEOUT cycles.
//                Late downstream responses are drained and discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_timeout_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                      axi_aclk,
   input  logic                      axi_areset,
   axi_lite_timeout_bridge_if.slave  s_axi,
   axi_lite_timeout_bridge_if.master m_axi,
   output logic                      wr_timeout,
   output logic                      rd_timeout,
   output logic [15:0]               timeout_count
);
   localparam int          STRB_WIDTH  = DATA_WIDTH / 8;
   localparam logic [15:0] TMR_LAST    = 16'(TIMEOUT - 1);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {W_IDLE, W_REQ, W_RESP, W_BRSP, W_ERR, W_DRAIN} wr_state_t;
   typedef enum logic [2:0] {R_IDLE, R_REQ, R_RESP, R_RDAT, R_ERR, R_DRAIN} rd_state_t;

   // write path state
   wr_state_t               wr_state_q, wr_state_d;
   logic                    m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
   logic                    m_bready_q, m_bready_d;
   logic [ADDR_WIDTH-1:0]   m_awaddr_q, m_awaddr_d;
   logic [2:0]              m_awprot_q, m_awprot_d;
   logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
   logic [STRB_WIDTH-1:0]   m_wstrb_q, m_wstrb_d;
   logic                    s_bvalid_q, s_bvalid_d;
   logic [1:0]              s_bresp_q, s_bresp_d;
   logic [15:0]             wr_timer_q, wr_timer_d;
   logic                    wr_bdone_q, wr_bdone_d;
   logic                    wr_timeout_q, wr_timeout_d;
   // read path state
   rd_state_t               rd_state_q, rd_state_d;
   logic                    m_arvalid_q, m_arvalid_d;
   logic                    m_rready_q, m_rready_d;
   logic [ADDR_WIDTH-1:0]   m_araddr_q, m_araddr_d;
   logic [2:0]              m_arprot_q, m_arprot_d;
   logic                    s_rvalid_q, s_rvalid_d;
   logic [1:0]              s_rresp_q, s_rresp_d;
   logic [DATA_WIDTH-1:0]   s_rdata_q, s_rdata_d;
   logic [15:0]             rd_timer_q, rd_timer_d;
   logic                    rd_rdone_q, rd_rdone_d;
   logic                    rd_timeout_q, rd_timeout_d;
   // shared
   logic [15:0]             timeout_count_q, timeout_count_d;
   logic [16:0]             count_sum;

   // upstream accepts only in IDLE; the only combinational s-side outputs
   logic wr_accept, rd_accept, b_hs, r_hs;
   assign wr_accept = (wr_state_q == W_IDLE) & s_axi.awvalid & s_axi.wvalid;
   assign rd_accept = (rd_state_q == R_IDLE) & s_axi.arvalid;
   assign b_hs      = m_axi.bvalid & m_bready_q;
   assign r_hs      = m_axi.rvalid & m_rready_q;

   assign s_axi.awready = wr_accept;
   assign s_axi.wready  = wr_accept;
   assign s_axi.arready = rd_accept;
   assign s_axi.bvalid  = s_bvalid_q;
   assign s_axi.bresp   = s_bresp_q;
   assign s_axi.rvalid  = s_rvalid_q;
   assign s_axi.rresp   = s_rresp_q;
   assign s_axi.rdata   = s_rdata_q;
   assign m_axi.awvalid = m_awvalid_q;
   assign m_axi.awaddr  = m_awaddr_q;
   assign m_axi.awprot  = m_awprot_q;
   assign m_axi.wvalid  = m_wvalid_q;
   assign m_axi.wdata   = m_wdata_q;
   assign m_axi.wstrb   = m_wstrb_q;
   assign m_axi.bready  = m_bready_q;
   assign m_axi.arvalid = m_arvalid_q;
   assign m_axi.araddr  = m_araddr_q;
   assign m_axi.arprot  = m_arprot_q;
   assign m_axi.rready  = m_rready_q;
   assign wr_timeout    = wr_timeout_q;
   assign rd_timeout    = rd_timeout_q;
   assign timeout_count = timeout_count_q;

   // write FSM next state: launch, wait for B or expiry, reply, drain late B
   always_comb begin
      wr_state_d   = wr_state_q;
      m_awvalid_d  = m_awvalid_q & ~m_axi.awready;
      m_wvalid_d   = m_wvalid_q & ~m_axi.wready;
      m_awaddr_d   = m_awaddr_q;
      m_awprot_d   = m_awprot_q;
      m_wdata_d    = m_wdata_q;
      m_wstrb_d    = m_wstrb_q;
      s_bvalid_d   = s_bvalid_q;
      s_bresp_d    = s_bresp_q;
      wr_timer_d   = wr_timer_q;
      wr_bdone_d   = wr_bdone_q | b_hs;
      wr_timeout_d = 1'b0;
      case (wr_state_q)
         W_IDLE: if (wr_accept) begin
            m_awaddr_d  = s_axi.awaddr;
            m_awprot_d  = s_axi.awprot;
            m_wdata_d   = s_axi.wdata;
            m_wstrb_d   = s_axi.wstrb;
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
            wr_timer_d  = 16'd0;
            wr_bdone_d  = 1'b0;
            wr_state_d  = W_REQ;
         end
         W_REQ: begin
            wr_timer_d = wr_timer_q + 16'd1;
            if (wr_timer_q == TMR_LAST) begin
               wr_timeout_d = 1'b1;
               s_bvalid_d   = 1'b1;
               s_bresp_d    = RESP_SLVERR;
               wr_state_d   = W_ERR;
            end else if (!m_awvalid_d && !m_wvalid_d) begin
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            wr_timer_d = wr_timer_q + 16'd1;
            // a response in the expiry cycle still wins over the timeout
            if (b_hs) begin
               s_bvalid_d = 1'b1;
               s_bresp_d  = m_axi.bresp;
               wr_state_d = W_BRSP;
            end else if (wr_timer_q == TMR_LAST) begin
               wr_timeout_d = 1'b1;
               s_bvalid_d   = 1'b1;
               s_bresp_d    = RESP_SLVERR;
               wr_state_d   = W_ERR;
            end
         end
         W_BRSP: if (s_axi.bready) begin
            s_bvalid_d = 1'b0;
            wr_state_d = W_IDLE;
         end
         W_ERR: if (s_axi.bready) begin
            s_bvalid_d = 1'b0;
            wr_state_d = wr_bdone_d ? W_IDLE : W_DRAIN;
         end
         W_DRAIN: if (wr_bdone_d) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
      // B is only accepted once AW and W are both through and B is still owed
      m_bready_d = ((wr_state_d == W_RESP) || (wr_state_d == W_ERR) || (wr_state_d == W_DRAIN))
                   & ~m_awvalid_d & ~m_wvalid_d & ~wr_bdone_d;
   end

   // read FSM next state: mirror of the write path with R carrying data
   always_comb begin
      rd_state_d   = rd_state_q;
      m_arvalid_d  = m_arvalid_q & ~m_axi.arready;
      m_araddr_d   = m_araddr_q;
      m_arprot_d   = m_arprot_q;
      s_rvalid_d   = s_rvalid_q;
      s_rresp_d    = s_rresp_q;
      s_rdata_d    = s_rdata_q;
      rd_timer_d   = rd_timer_q;
      rd_rdone_d   = rd_rdone_q | r_hs;
      rd_timeout_d = 1'b0;
      case (rd_state_q)
         R_IDLE: if (rd_accept) begin
            m_araddr_d  = s_axi.araddr;
            m_arprot_d  = s_axi.arprot;
            m_arvalid_d = 1'b1;
            rd_timer_d  = 16'd0;
            rd_rdone_d  = 1'b0;
            rd_state_d  = R_REQ;
         end
         R_REQ: begin
            rd_timer_d = rd_timer_q + 16'd1;
            if (rd_timer_q == TMR_LAST) begin
               rd_timeout_d = 1'b1;
               s_rvalid_d   = 1'b1;
               s_rresp_d    = RESP_SLVERR;
               s_rdata_d    = '0;
               rd_state_d   = R_ERR;
            end else if (!m_arvalid_d) begin
               rd_state_d = R_RESP;
            end
         end
         R_RESP: begin
            rd_timer_d = rd_timer_q + 16'd1;
            if (r_hs) begin
               s_rvalid_d = 1'b1;
               s_rresp_d  = m_axi.rresp;
               s_rdata_d  = m_axi.rdata;
               rd_state_d = R_RDAT;
            end else if (rd_timer_q == TMR_LAST) begin
               rd_timeout_d = 1'b1;
               s_rvalid_d   = 1'b1;
               s_rresp_d    = RESP_SLVERR;
               s_rdata_d    = '0;
               rd_state_d   = R_ERR;
            end
         end
         R_RDAT: if (s_axi.rready) begin
            s_rvalid_d = 1'b0;
            rd_state_d = R_IDLE;
         end
         R_ERR: if (s_axi.rready) begin
            s_rvalid_d = 1'b0;
            rd_state_d = rd_rdone_d ? R_IDLE : R_DRAIN;
         end
         R_DRAIN: if (rd_rdone_d) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
      m_rready_d = ((rd_state_d == R_RESP) || (rd_state_d == R_ERR) || (rd_state_d == R_DRAIN))
                   & ~m_arvalid_d & ~rd_rdone_d;
   end

   // saturating timeout tally; both paths may fire in the same cycle
   always_comb begin
      count_sum       = {1'b0, timeout_count_q} + 17'(wr_timeout_d) + 17'(rd_timeout_d);
      timeout_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
   end

   // state register for both paths; reset drops every valid immediately
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         wr_state_q      <= W_IDLE;
         m_awvalid_q     <= 1'b0;
         m_wvalid_q      <= 1'b0;
         m_bready_q      <= 1'b0;
         m_awaddr_q      <= '0;
         m_awprot_q      <= '0;
         m_wdata_q       <= '0;
         m_wstrb_q       <= '0;
         s_bvalid_q      <= 1'b0;
         s_bresp_q       <= RESP_OKAY;
         wr_timer_q      <= 16'd0;
         wr_bdone_q      <= 1'b0;
         wr_timeout_q    <= 1'b0;
         rd_state_q      <= R_IDLE;
         m_arvalid_q     <= 1'b0;
         m_rready_q      <= 1'b0;
         m_araddr_q      <= '0;
         m_arprot_q      <= '0;
         s_rvalid_q      <= 1'b0;
         s_rresp_q       <= RESP_OKAY;
         s_rdata_q       <= '0;
         rd_timer_q      <= 16'd0;
         rd_rdone_q      <= 1'b0;
         rd_timeout_q    <= 1'b0;
         timeout_count_q <= 16'd0;
      end else begin
         wr_state_q      <= wr_state_d;
         m_awvalid_q     <= m_awvalid_d;
         m_wvalid_q      <= m_wvalid_d;
         m_bready_q      <= m_bready_d;
         m_awaddr_q      <= m_awaddr_d;
         m_awprot_q      <= m_awprot_d;
         m_wdata_q       <= m_wdata_d;
         m_wstrb_q       <= m_wstrb_d;
         s_bvalid_q      <= s_bvalid_d;
         s_bresp_q       <= s_bresp_d;
         wr_timer_q      <= wr_timer_d;
         wr_bdone_q      <= wr_bdone_d;
         wr_timeout_q    <= wr_timeout_d;
         rd_state_q      <= rd_state_d;
         m_arvalid_q     <= m_arvalid_d;
         m_rready_q      <= m_rready_d;
         m_araddr_q      <= m_araddr_d;
         m_arprot_q      <= m_arprot_d;
         s_rvalid_q      <= s_rvalid_d;
         s_rresp_q       <= s_rresp_d;
         s_rdata_q       <= s_rdata_d;
         rd_timer_q      <= rd_timer_d;
         rd_rdone_q      <= rd_rdone_d;
         rd_timeout_q    <= rd_timeout_d;
         timeout_count_q <= timeout_count_d;
      end
   end
endmodule
`default_nettype wire
